uart_rx_deserializer: RTL and testbench
=======================================

Name: uart_rx_deserializer

Overview:
- Serial-to-parallel UART receiver for the debug unit, format 8N1, LSB first, line idles high.
- Sits directly upstream of the instruction-load FSM and the other debug FSMs, which consume its one-cycle done strobe and held data byte.
- Each valid frame produces one byte and one strobe.
- Contains its own oversampling tick generator, so no external baud-rate block is needed.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD_RATE, 19200, line rate in bits/s
OVERSAMPLE, 16, ticks per bit period (even, >= 8)
UART_BITS, 8, data bits per frame
TICK_DIV, CLK_FREQ/(BAUD_RATE*OVERSAMPLE), clocks per tick (integer truncation, >= 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
i_rx  in  1  asynchronous serial input, idle high
o_rx_done  out  1  one-cycle strobe: new valid byte on o_rx_data
o_rx_data  out  UART_BITS  last valid byte; held until the next valid frame
o_frame_err  out  1  one-cycle strobe: stop bit sampled low

Behaviour:
Reset and clocking:
- Reset: synchronous, active-low rst; clock clk; all state updates on posedge clk.
- While rst=0: o_rx_done=0, o_rx_data=0, o_frame_err=0, state=IDLE, counters=0, both synchronizer flops=1.

Input synchronizer and tick generator:
- i_rx passes through a 2-flop synchronizer; the FSM uses only the synchronized value rx_s.
- Tick generator: counter runs 0..TICK_DIV-1; tick=1 for one clk when the counter equals TICK_DIV-1, then it wraps to 0.
- The tick counter is held at 0 while in IDLE, so sampling phase is aligned to start-bit detection.

State machine: IDLE, START, DATA, STOP.
- IDLE: rx_s=0 -> START, with tick_cnt=0 and bit_idx=0. Otherwise stay.
- START: tick_cnt increments on each tick. At the tick where tick_cnt=OVERSAMPLE/2-1 (mid start bit):
  - rx_s=0 -> DATA, tick_cnt=0.
  - rx_s=1 -> IDLE (glitch rejected, no strobe).
- DATA: tick_cnt increments on each tick. At the tick where tick_cnt=OVERSAMPLE-1 (mid data bit):
  - shift register <= {rx_s, shift[UART_BITS-1:1]} (LSB received first).
  - tick_cnt=0, bit_idx+1.
  - After the UART_BITS-th sample -> STOP.
- STOP: at the tick where tick_cnt=OVERSAMPLE-1:
  - rx_s=1 -> o_rx_data<=shift, o_rx_done=1 for exactly that one clk, then IDLE.
  - rx_s=0 -> o_frame_err=1 for one clk, o_rx_data unchanged, no o_rx_done, then IDLE.

Outputs and timing:
- Outputs are registered.
- o_rx_done and o_frame_err are never high together, and each is high for at most one clk per frame.
- Latency: o_rx_done rises (OVERSAMPLE/2 + OVERSAMPLE*(UART_BITS+1))*TICK_DIV + 3 to +4 clks after the falling edge of the start bit on i_rx. That is 9.5 bit periods + sync delay.

Boundary conditions:
- Back-to-back frames (stop bit immediately followed by the next start bit) must be received without loss. The return to IDLE occurs half a bit before the stop bit ends.
- Break condition (line held low) yields a framing error. Because IDLE starts on low level, a held break then re-enters START and repeats the framing error every frame period.
- Reset mid-frame: the FSM returns to IDLE, the partial byte is discarded, and outputs are cleared.
- Transition from IDLE to START requires no edge, only rx_s=0.
- The tick counter wraps only through its reset-to-0 rule; bit_idx width is clog2(UART_BITS)+1 so it cannot wrap inside a frame.

Test Plan:
(Bench parameters: CLK_FREQ=1600000, BAUD_RATE=10000, OVERSAMPLE=16 -> TICK_DIV=10, 160 clks/bit.)
1. Single frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) -> one o_rx_done pulse 1523-1524 clks after start edge; o_rx_data=0xA5; o_frame_err never 1.
2. Back-to-back frames 0x03, 0x12, 0x34 with no idle gap -> exactly three o_rx_done pulses, 1600 clks apart; data 0x03, 0x12, 0x34 in order, each held until the next strobe.
3. Glitch: i_rx low for 50 clks, then high -> FSM returns to IDLE; no o_rx_done, no o_frame_err; a following 0x5A frame is received correctly.
4. Framing error: frame 0x77 with stop bit driven low, preceded by a valid 0x11 -> o_frame_err pulses once; o_rx_done does not pulse; o_rx_data stays 0x11.
5. Reset mid-frame: rst=0 for 5 clks during bit 3 of 0xC3, line high on release -> all outputs 0; the next frame 0x3C gives o_rx_data=0x3C and exactly one o_rx_done.
6. Extremes 0x00 then 0xFF -> o_rx_data=0x00 then 0xFF, one o_rx_done pulse each, no o_frame_err.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: 2-flop input synchronizer, internal oversampling tick
// generator and a start/data/stop FSM producing one byte per valid frame.
module uart_rx_deserializer #(
   parameter int CLK_FREQ   = 100000000,
   parameter int BAUD_RATE  = 19200,
   parameter int OVERSAMPLE = 16,
   parameter int UART_BITS  = 8,
   parameter int TICK_DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_rx,
   output logic                 o_rx_done,
   output logic [UART_BITS-1:0] o_rx_data,
   output logic                 o_frame_err,
   output logic [1:0]           o_state
);

   localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int OS_W  = $clog2(OVERSAMPLE);
   localparam int IDX_W = $clog2(UART_BITS) + 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_BITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t               state;
   logic                 rx_meta;
   logic                 rx_s;
   logic [DIV_W-1:0]     div_cnt;
   logic                 tick;
   logic [OS_W-1:0]      tick_cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic [UART_BITS-1:0] shift;

   assign o_state = state;

   // Synchronizer resets to the idle line level so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= i_rx;
         rx_s    <= rx_meta;
      end
   end

   // Held at 0 in IDLE so every frame's sampling phase starts at start-bit detection.
   always_ff @(posedge clk) begin
      if (!rst || state == IDLE) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign tick = (div_cnt == DIV_LAST);

   // Handshake: o_rx_done is a valid-only strobe with no ready; o_rx_data holds
   // the byte until the next valid frame, so a consumer may capture it any time.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         tick_cnt    <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         o_rx_done   <= 1'b0;
         o_rx_data   <= '0;
         o_frame_err <= 1'b0;
      end else begin
         o_rx_done   <= 1'b0;
         o_frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state    <= START;
                  tick_cnt <= '0;
                  bit_idx  <= '0;
               end
            end
            START: begin
               if (tick) begin
                  if (tick_cnt == OS_MID) begin
                     tick_cnt <= '0;
                     state    <= rx_s ? IDLE : DATA;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (tick_cnt == OS_LAST) begin
                     shift    <= {rx_s, shift[UART_BITS-1:1]};
                     tick_cnt <= '0;
                     bit_idx  <= bit_idx + 1'b1;
                     if (bit_idx == IDX_LAST) begin
                        state <= STOP;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            STOP: begin
               // Leaving at mid stop bit gives half a bit of slack for back-to-back frames.
               if (tick) begin
                  if (tick_cnt == OS_LAST) begin
                     tick_cnt <= '0;
                     state    <= IDLE;
                     if (rx_s) begin
                        o_rx_data <= shift;
                        o_rx_done <= 1'b1;
                     end else begin
                        o_frame_err <= 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed testbench for uart_rx_deserializer at 160 clks per bit (TICK_DIV=10).
module tb_uart_rx_deserializer;

   localparam int CLK_FREQ   = 1600000;
   localparam int BAUD_RATE  = 10000;
   localparam int OVERSAMPLE = 16;
   localparam int UART_BITS  = 8;
   localparam int BIT_CLKS   = 160;
   localparam int FRAME_CLKS = 1600;
   localparam int LAT_MIN    = 1523;
   localparam int LAT_MAX    = 1524;
   localparam logic [1:0] ST_IDLE = 2'd0;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       i_rx = 1'b1;
   logic       o_rx_done;
   logic [7:0] o_rx_data;
   logic       o_frame_err;
   logic [1:0] o_state;

   int checks   = 0;
   int failures = 0;

   uart_rx_deserializer #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD_RATE  (BAUD_RATE),
      .OVERSAMPLE (OVERSAMPLE),
      .UART_BITS  (UART_BITS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_rx        (i_rx),
      .o_rx_done   (o_rx_done),
      .o_rx_data   (o_rx_data),
      .o_frame_err (o_frame_err),
      .o_state     (o_state)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   logic [7:0]  exp_q[$];
   logic [7:0]  got_q[$];
   int unsigned got_cyc_q[$];
   logic [7:0]  pre_q[$];
   int          fe_cnt    = 0;
   int          both_cnt  = 0;
   int          wide_cnt  = 0;
   logic        prev_done = 1'b0;
   logic        prev_fe   = 1'b0;
   logic [7:0]  prev_data = 8'h00;

   always @(posedge clk) begin
      #1;
      if (o_rx_done) begin
         got_q.push_back(o_rx_data);
         got_cyc_q.push_back(cyc);
         pre_q.push_back(prev_data);
      end
      if (o_frame_err) fe_cnt++;
      if (o_rx_done && o_frame_err) both_cnt++;
      if ((o_rx_done && prev_done) || (o_frame_err && prev_fe)) wide_cnt++;
      prev_done = o_rx_done;
      prev_fe   = o_frame_err;
      prev_data = o_rx_data;
   end

   // ---------------- driver tasks (called just after a negedge) ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                             output int unsigned fall_cyc);
      i_rx = 1'b0;
      fall_cyc = cyc;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         i_rx = b[i];
         repeat (BIT_CLKS) @(negedge clk);
      end
      i_rx = stop_bit;
      repeat (BIT_CLKS) @(negedge clk);
      i_rx = 1'b1;
   endtask

   task automatic clear_sb();
      exp_q.delete();
      got_q.delete();
      got_cyc_q.delete();
      pre_q.delete();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      idle(3);
      checks++;
      if (o_rx_done !== 1'b0) begin
         failures++; $display("FAIL reset_done: got %b expected 0", o_rx_done);
      end
      checks++;
      if (o_rx_data !== 8'h00) begin
         failures++; $display("FAIL reset_data: got %h expected 00", o_rx_data);
      end
      checks++;
      if (o_frame_err !== 1'b0) begin
         failures++; $display("FAIL reset_ferr: got %b expected 0", o_frame_err);
      end
      checks++;
      if (o_state !== ST_IDLE) begin
         failures++; $display("FAIL reset_state: got %0d expected %0d", o_state, ST_IDLE);
      end
      rst = 1'b1;
      idle(20);
   endtask

   task automatic test_single();
      int unsigned fall;
      int fe0;
      int lat;
      clear_sb();
      fe0 = fe_cnt;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, fall);
      idle(40);
      checks++;
      if (got_q.size() !== 1) begin
         failures++; $display("FAIL single_count: got %0d expected 1", got_q.size());
      end
      checks++;
      if (((got_q.size() > 0) ? got_q[0] : 8'hxx) !== exp_q[0]) begin
         failures++; $display("FAIL single_data: got %h expected %h",
                              (got_q.size() > 0) ? got_q[0] : 8'hxx, exp_q[0]);
      end
      lat = (got_cyc_q.size() > 0) ? int'(got_cyc_q[0] - fall) : -1;
      checks++;
      if (lat < LAT_MIN || lat > LAT_MAX) begin
         failures++; $display("FAIL single_latency: got %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
      end
      checks++;
      if (fe_cnt !== fe0) begin
         failures++; $display("FAIL single_ferr: got %0d expected %0d", fe_cnt, fe0);
      end
   endtask

   task automatic test_back_to_back();
      int unsigned fall;
      int fe0;
      logic [7:0] bytes[3];
      bytes = '{8'h03, 8'h12, 8'h34};
      clear_sb();
      fe0 = fe_cnt;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(bytes[i]);
         send_frame(bytes[i], 1'b1, fall);
      end
      idle(40);
      checks++;
      if (got_q.size() !== 3) begin
         failures++; $display("FAIL b2b_count: got %0d expected 3", got_q.size());
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (((i < got_q.size()) ? got_q[i] : 8'hxx) !== exp_q[i]) begin
            failures++; $display("FAIL b2b_data%0d: got %h expected %h", i,
                                 (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
         end
      end
      for (int i = 1; i < 3; i++) begin
         int gap;
         gap = (i < got_cyc_q.size()) ? int'(got_cyc_q[i] - got_cyc_q[i-1]) : -1;
         checks++;
         if (gap !== FRAME_CLKS) begin
            failures++; $display("FAIL b2b_gap%0d: got %0d expected %0d", i, gap, FRAME_CLKS);
         end
         checks++;
         if (((i < pre_q.size()) ? pre_q[i] : 8'hxx) !== exp_q[i-1]) begin
            failures++; $display("FAIL b2b_hold%0d: got %h expected %h", i,
                                 (i < pre_q.size()) ? pre_q[i] : 8'hxx, exp_q[i-1]);
         end
      end
      checks++;
      if (fe_cnt !== fe0) begin
         failures++; $display("FAIL b2b_ferr: got %0d expected %0d", fe_cnt, fe0);
      end
   endtask

   task automatic test_glitch();
      int unsigned fall;
      int fe0;
      clear_sb();
      fe0 = fe_cnt;
      i_rx = 1'b0;
      idle(50);
      i_rx = 1'b1;
      idle(200);
      checks++;
      if (o_state !== ST_IDLE) begin
         failures++; $display("FAIL glitch_state: got %0d expected %0d", o_state, ST_IDLE);
      end
      checks++;
      if (got_q.size() !== 0 || fe_cnt !== fe0) begin
         failures++; $display("FAIL glitch_strobe: got done=%0d ferr=%0d expected 0 0",
                              got_q.size(), fe_cnt - fe0);
      end
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1, fall);
      idle(40);
      checks++;
      if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin
         failures++; $display("FAIL glitch_next: got count=%0d data=%h expected 1 %h",
                              got_q.size(), o_rx_data, exp_q[0]);
      end
   endtask

   task automatic test_frame_err();
      int unsigned fall;
      int fe0;
      clear_sb();
      fe0 = fe_cnt;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1, fall);
      send_frame(8'h77, 1'b0, fall);
      idle(320);
      checks++;
      if (fe_cnt - fe0 !== 1) begin
         failures++; $display("FAIL ferr_count: got %0d expected 1", fe_cnt - fe0);
      end
      checks++;
      if (got_q.size() !== 1) begin
         failures++; $display("FAIL ferr_done: got %0d expected 1", got_q.size());
      end
      checks++;
      if (o_rx_data !== exp_q[0]) begin
         failures++; $display("FAIL ferr_data_hold: got %h expected %h", o_rx_data, exp_q[0]);
      end
   endtask

   task automatic test_reset_mid();
      int unsigned fall;
      logic [7:0] b;
      clear_sb();
      b = 8'hC3;
      i_rx = 1'b0;
      idle(BIT_CLKS);
      for (int i = 0; i < 3; i++) begin
         i_rx = b[i];
         idle(BIT_CLKS);
      end
      i_rx = b[3];
      idle(BIT_CLKS / 2);
      rst  = 1'b0;
      i_rx = 1'b1;
      idle(5);
      checks++;
      if (o_rx_done !== 1'b0 || o_frame_err !== 1'b0 || o_rx_data !== 8'h00) begin
         failures++; $display("FAIL midrst_outputs: got done=%b ferr=%b data=%h expected 0 0 00",
                              o_rx_done, o_frame_err, o_rx_data);
      end
      checks++;
      if (o_state !== ST_IDLE) begin
         failures++; $display("FAIL midrst_state: got %0d expected %0d", o_state, ST_IDLE);
      end
      rst = 1'b1;
      idle(320);
      checks++;
      if (got_q.size() !== 0 || o_rx_data !== 8'h00) begin
         failures++; $display("FAIL midrst_discard: got count=%0d data=%h expected 0 00",
                              got_q.size(), o_rx_data);
      end
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1, fall);
      idle(40);
      checks++;
      if (got_q.size() !== 1 || o_rx_data !== exp_q[0]) begin
         failures++; $display("FAIL midrst_next: got count=%0d data=%h expected 1 %h",
                              got_q.size(), o_rx_data, exp_q[0]);
      end
   endtask

   task automatic test_extremes();
      int unsigned fall;
      int fe0;
      clear_sb();
      fe0 = fe_cnt;
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      send_frame(8'h00, 1'b1, fall);
      send_frame(8'hFF, 1'b1, fall);
      idle(40);
      checks++;
      if (got_q.size() !== 2) begin
         failures++; $display("FAIL ext_count: got %0d expected 2", got_q.size());
      end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (((i < got_q.size()) ? got_q[i] : 8'hxx) !== exp_q[i]) begin
            failures++; $display("FAIL ext_data%0d: got %h expected %h", i,
                                 (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
         end
      end
      checks++;
      if (fe_cnt !== fe0) begin
         failures++; $display("FAIL ext_ferr: got %0d expected %0d", fe_cnt, fe0);
      end
   endtask

   task automatic test_strobe_rules();
      checks++;
      if (both_cnt !== 0) begin
         failures++; $display("FAIL strobe_overlap: got %0d expected 0", both_cnt);
      end
      checks++;
      if (wide_cnt !== 0) begin
         failures++; $display("FAIL strobe_width: got %0d expected 0", wide_cnt);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      @(negedge clk);
      test_reset();
      test_single();
      idle(320);
      test_back_to_back();
      idle(320);
      test_glitch();
      idle(320);
      test_frame_err();
      test_reset_mid();
      idle(320);
      test_extremes();
      test_strobe_rules();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
